// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - data-memory request/response port of the load/store unit
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller with lane steering and load extension
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        mren,
    input  logic [1:0]        mwen,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    lsu_ctrl_if.master        mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic              accept;
    logic [1:0]        size;
    logic              illegal, misaligned, noop;
    logic [1:0]        ld_size;
    logic              ld_unsigned;
    logic [1:0]        off;
    logic              err_q;
    logic [DATA_W-1:0] wdata_lane;
    logic [3:0]        wstrb_lane;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;

    assign accept     = req_valid && req_ready;
    assign size       = mren | mwen;
    assign illegal    = (mren != 2'b00) && (mwen != 2'b00);
    assign misaligned = (size == 2'b10 && addr[0]) || (size == 2'b11 && addr[1:0] != 2'b00);
    assign noop       = (size == 2'b00);

    always_comb begin
        wdata_lane = wdata;
        wstrb_lane = 4'b0000;
        case (mwen)
            2'b01: begin
                wdata_lane = {4{wdata[7:0]}};
                wstrb_lane = 4'b0001 << addr[1:0];
            end
            2'b10: begin
                wdata_lane = {2{wdata[15:0]}};
                wstrb_lane = 4'b0011 << addr[1:0];
            end
            2'b11:   wstrb_lane = 4'b1111;
            default: wstrb_lane = 4'b0000;
        endcase
    end

    // Stores leave ld_size at zero so the captured result is zero.
    always_comb begin
        ld_byte = mem.mem_rdata[{off, 3'b000} +: 8];
        ld_half = mem.mem_rdata[{off[1], 4'b0000} +: 16];
        case (ld_size)
            2'b01:   ld_ext = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            2'b10:   ld_ext = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            2'b11:   ld_ext = mem.mem_rdata;
            default: ld_ext = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx          = state;
        req_ready         = 1'b0;
        done              = 1'b0;
        err               = 1'b0;
        mem.mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_nx = (illegal || misaligned || noop) ? DONE : REQ;
            end
            REQ: begin
                mem.mem_req_valid = 1'b1;
                if (mem.mem_req_ready) state_nx = WAIT;
            end
            WAIT: begin
                if (mem.mem_resp_valid) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_size       <= 2'b00;
            ld_unsigned   <= 1'b0;
            off           <= 2'b00;
            err_q         <= 1'b0;
            rdata         <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= 4'b0000;
        end else begin
            if (accept) begin
                ld_size       <= mren;
                ld_unsigned   <= load_unsigned;
                off           <= addr[1:0];
                err_q         <= illegal || misaligned;
                mem.mem_we    <= (mwen != 2'b00);
                mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                mem.mem_wdata <= wdata_lane;
                mem.mem_wstrb <= wstrb_lane;
                if (noop) rdata <= '0;
            end
            if (state == WAIT && mem.mem_resp_valid) rdata <= ld_ext;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a randomized memory responder
`timescale 1ns/1ps
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, load_unsigned, done, err;
    logic [1:0]  mren, mwen;
    logic [31:0] addr, wdata, rdata;

    lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) m ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mren(mren), .mwen(mwen), .load_unsigned(load_unsigned), .addr(addr),
        .wdata(wdata), .done(done), .err(err), .rdata(rdata), .mem(m)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic err; int lat; int t0; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int rs; int ws; } memreq_t;

    resp_t       resp_q[$];
    memreq_t     req_q[$];
    logic [31:0] model_mem [16];
    logic [31:0] exp_rdata = 32'h0;
    logic        auto_mem = 1'b1;
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected results come from byte arithmetic on a word array.
    task automatic issue(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int rs, input int ws);
        resp_t       r;
        memreq_t     q;
        int          sz, off, n;
        logic        bad;
        logic [31:0] mask, v;
        sz  = (rd != 0) ? (1 << (int'(rd) - 1)) : ((wr != 0) ? (1 << (int'(wr) - 1)) : 0);
        off = int'(a % 4);
        bad = (rd != 0 && wr != 0) || (sz > 1 && (a % sz) != 0);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        r.err = bad;
        r.lat = (bad || sz == 0) ? 1 : 3 + rs + ws;
        if (bad)          r.rdata = exp_rdata;
        else if (rd == 0) r.rdata = 32'h0;
        else begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
            v = (model_mem[a[5:2]] >> (8 * off)) & mask;
            if (!uns && v[8 * sz - 1]) v = v | ~mask;
            r.rdata = v;
        end
        exp_rdata = r.rdata;
        if (!bad && sz != 0) begin
            q.we = (wr != 0);
            q.addr = {a[31:2], 2'b00};
            q.wstrb = 4'b0000;
            q.wdata = 32'h0;
            q.rs = rs;
            q.ws = ws;
            if (q.we) begin
                for (int i = 0; i < sz; i++) begin
                    q.wstrb[off + i] = 1'b1;
                    model_mem[a[5:2]][8 * (off + i) +: 8] = wd[8 * i +: 8];
                end
                for (int j = 0; j < 4; j++) q.wdata[8 * j +: 8] = wd[8 * (j % sz) +: 8];
            end
            req_q.push_back(q);
        end
        mren = rd; mwen = wr; load_unsigned = uns; addr = a; wdata = wd; req_valid = 1'b1;
        r.t0 = cyc;
        resp_q.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
        mren = 2'($urandom); mwen = 2'($urandom); addr = $urandom; wdata = $urandom;
        load_unsigned = 1'($urandom);
    endtask

    // Memory responder; stray responses outside WAIT must be ignored by the DUT.
    initial begin
        memreq_t q;
        m.mem_req_ready = 1'b0; m.mem_resp_valid = 1'b0; m.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (auto_mem && !rst) begin
                m.mem_req_ready = 1'b0;
                m.mem_resp_valid = 1'($urandom_range(0, 1));
                m.mem_rdata = $urandom;
                if (m.mem_req_valid) begin
                    if (req_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_mem_req: got addr 0x%08h expected no request", m.mem_addr);
                    end else begin
                        q = req_q.pop_front();
                        chk("mem_we", 32'(m.mem_we), 32'(q.we));
                        chk("mem_addr", m.mem_addr, q.addr);
                        if (q.we) begin
                            chk("mem_wdata", m.mem_wdata, q.wdata);
                            chk("mem_wstrb", 32'(m.mem_wstrb), 32'(q.wstrb));
                        end
                        for (int i = 0; i < q.rs; i++) begin
                            @(negedge clk);
                            m.mem_resp_valid = 1'($urandom_range(0, 1));
                            m.mem_rdata = $urandom;
                            chk("hold_ctrl", {m.mem_req_valid, m.mem_we, m.mem_wstrb}, {1'b1, q.we, (q.we ? q.wstrb : m.mem_wstrb)});
                            chk("hold_addr", m.mem_addr, q.addr);
                            if (q.we) chk("hold_wdata", m.mem_wdata, q.wdata);
                        end
                        m.mem_req_ready = 1'b1;
                        m.mem_resp_valid = 1'($urandom_range(0, 1));
                        m.mem_rdata = $urandom;
                        @(negedge clk);
                        m.mem_req_ready = 1'b0;
                        m.mem_resp_valid = 1'b0;
                        repeat (q.ws) @(negedge clk);
                        m.mem_resp_valid = 1'b1;
                        m.mem_rdata = q.we ? $urandom : model_mem[q.addr[5:2]];
                    end
                end
            end
        end
    end

    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) begin
                    if (resp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_done: got done=1 expected 0");
                    end else begin
                        r = resp_q.pop_front();
                        chk("rdata", rdata, r.rdata);
                        chk("err", 32'(err), 32'(r.err));
                        chk("latency", 32'(cyc - r.t0), 32'(r.lat));
                    end
                end else if (err) begin
                    compared++;
                    mismatched++;
                    $display("FAIL err_without_done: got err=1 expected 0");
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, sz, n;
        logic [1:0] s;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; mren = 2'b00; mwen = 2'b00; load_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        for (int i = 0; i < 16; i++) model_mem[i] = $urandom;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_done_err", {done, err}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_ctrl", {m.mem_req_valid, m.mem_we, m.mem_wstrb}, 32'd0);
        chk("rst_mem_addr", m.mem_addr, 32'h0);
        chk("rst_mem_wdata", m.mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        model_mem[0] = 32'h8012_3456;
        issue(2'b01, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 0, 0);
        issue(2'b00, 2'b10, 1'b0, 32'h8000_0102, 32'h0000_ABCD, 0, 0);
        issue(2'b11, 2'b00, 1'b0, 32'h8000_0001, 32'h0, 0, 0);
        issue(2'b11, 2'b00, 1'b0, 32'h8000_0104, 32'h0, 3, 1);
        issue(2'b00, 2'b00, 1'b0, 32'h8000_0008, 32'h1234_5678, 0, 0);
        issue(2'b01, 2'b01, 1'b0, 32'h8000_0008, 32'h1234_5678, 0, 0);

        for (int t = 0; t < 200; t++) begin
            k  = $urandom_range(0, 9);
            s  = 2'($urandom_range(1, 3));
            sz = 1 << (int'(s) - 1);
            a  = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 1);
            case (k)
                0:       issue(2'b00, 2'b00, 1'($urandom), a, $urandom, 0, 0);
                1:       issue(s, 2'($urandom_range(1, 3)), 1'($urandom), a, $urandom, 0, 0);
                2, 3, 4, 5: issue(s, 2'b00, 1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
                default: issue(2'b00, s, 1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            endcase
        end

        n = 0;
        while ((resp_q.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(resp_q.size()), 32'd0);

        // Reset while waiting for a read response; the late response must be dropped.
        auto_mem = 1'b0;
        m.mem_req_ready = 1'b0; m.mem_resp_valid = 1'b0;
        @(negedge clk);
        mren = 2'b11; mwen = 2'b00; addr = 32'h8000_0010; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_req_valid", 32'(m.mem_req_valid), 32'd1);
        m.mem_req_ready = 1'b1;
        @(negedge clk);
        m.mem_req_ready = 1'b0;
        chk("rw_in_wait", {req_ready, m.mem_req_valid, done}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rw_async_ready", 32'(req_ready), 32'd1);
        chk("rw_async_req_valid", 32'(m.mem_req_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m.mem_resp_valid = 1'b1;
        m.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        m.mem_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rw_no_done", {done, err, req_ready}, 32'd1);
            chk("rw_rdata", rdata, 32'h0);
            @(negedge clk);
        end
        chk("queues_empty", 32'(resp_q.size() + req_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
